// File: rtl/lut_ctrl_wb.sv
// lut_ctrl_wb -- drains one tile from the output buffer onto a valid/ready stream.
//
// A start pulse in IDLE latches the tile length N = K * HWCIJ. Reads then go to
// buffer addresses 0..N-1, one per cycle at most. Read data returns one cycle
// after rd_en and lands in a 2-entry FIFO. The FIFO head drives the stream.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   bs_subtile_K          K subtile count (sampled on accepted start)
//   bs_opt_subtile_HWCIJ  HW*CIJ product (sampled on accepted start)
//   bs_wb_tile_start      one-cycle request to drain a tile
//   bs_out_buf_wb_rd_en   output-buffer read enable
//   bs_out_buf_wb_addr    output-buffer read address
//   bs_out_buf_wb_rdata   read data, valid the cycle after rd_en
//   m_data/m_valid/m_last stream output, m_last marks beat N-1
//   m_ready               stream backpressure
//   bs_wb_busy            high while the FSM is not IDLE
//   bs_wb_tile_end        one-cycle pulse when the tile is finished
//
// state | meaning
// IDLE  | waiting for start; an N == 0 tile completes here
// RUN   | issuing reads, stream may already be flowing
// DRAIN | all reads issued, waiting for the last beat to be accepted

`ifndef HW_BS_OUT_BUF_DEPTH
`define HW_BS_OUT_BUF_DEPTH 10
`endif

module lut_ctrl_wb #(
  parameter int BS_OUT_BUF_DEPTH = `HW_BS_OUT_BUF_DEPTH,
  parameter int OUT_DATA_WIDTH   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  bs_subtile_K,
  input  logic [23:0]                 bs_opt_subtile_HWCIJ,
  input  logic                        bs_wb_tile_start,
  output logic                        bs_out_buf_wb_rd_en,
  output logic [BS_OUT_BUF_DEPTH-1:0] bs_out_buf_wb_addr,
  input  logic [OUT_DATA_WIDTH-1:0]   bs_out_buf_wb_rdata,
  output logic [OUT_DATA_WIDTH-1:0]   m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        bs_wb_busy,
  output logic                        bs_wb_tile_end
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_q;
  logic [31:0]               n_q;
  logic [31:0]               issue_q;
  logic [31:0]               beat_q;
  logic                      inflight_q;
  logic                      zero_end_q;
  logic [OUT_DATA_WIDTH-1:0] fifo_q [2];
  logic                      wr_ptr_q;
  logic                      rd_ptr_q;
  logic [1:0]                occ_q;

  logic [31:0] n_d;
  logic [1:0]  occ_d;
  logic [1:0]  occ_after_pop;
  logic        start_acc;
  logic        pop;

  // Stream and read-port outputs are decoded straight from registers so that
  // rd_en can fire the cycle after start and the head is visible as soon as
  // it is captured; this is what gives the 3-cycle start-to-valid latency.
  always_comb begin
    n_d       = {24'd0, bs_subtile_K} * {8'd0, bs_opt_subtile_HWCIJ};
    // A start landing on the zero-length tile_end pulse is dropped.
    start_acc = bs_wb_tile_start && (state_q == IDLE) && !zero_end_q;

    m_valid = (occ_q != 2'd0);
    pop     = m_valid && m_ready;
    m_data  = m_valid ? fifo_q[rd_ptr_q] : '0;
    m_last  = m_valid && (beat_q == n_q - 32'd1);

    // Credit counts the slot freed by this cycle's pop, which is what lets a
    // continuously-ready stream sustain one beat per cycle with two entries.
    occ_after_pop       = occ_q - {1'b0, pop};
    bs_out_buf_wb_rd_en = (state_q == RUN) && (issue_q != n_q) &&
                          ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);
    bs_out_buf_wb_addr  = issue_q[BS_OUT_BUF_DEPTH-1:0];

    bs_wb_busy     = (state_q != IDLE);
    bs_wb_tile_end = (pop && m_last) || zero_end_q;

    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      issue_q    <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      zero_end_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= '0;
    end else begin
      zero_end_q <= start_acc && (n_d == 32'd0);
      inflight_q <= bs_out_buf_wb_rd_en;
      occ_q      <= occ_d;

      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= bs_out_buf_wb_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        beat_q   <= beat_q + 32'd1;
      end
      if (bs_out_buf_wb_rd_en) begin
        issue_q <= issue_q + 32'd1;
      end

      unique case (state_q)
        IDLE: begin
          if (start_acc) begin
            n_q     <= n_d;
            issue_q <= '0;
            beat_q  <= '0;
            if (n_d != 32'd0) begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (bs_out_buf_wb_rd_en && (issue_q + 32'd1 == n_q)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_ctrl_wb.sv
module tb_lut_ctrl_wb;
  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    bs_subtile_K;
  logic [23:0]   bs_opt_subtile_HWCIJ;
  logic          bs_wb_tile_start;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          tile_end;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_q[$];
  logic          pend_rd = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic          s_rd = 1'b0;
  logic          s_pop = 1'b0;
  int            occ_m = 0;
  int            infl_m = 0;

  lut_ctrl_wb #(.BS_OUT_BUF_DEPTH(AW), .OUT_DATA_WIDTH(DW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bs_subtile_K         (bs_subtile_K),
    .bs_opt_subtile_HWCIJ (bs_opt_subtile_HWCIJ),
    .bs_wb_tile_start     (bs_wb_tile_start),
    .bs_out_buf_wb_rd_en  (rd_en),
    .bs_out_buf_wb_addr   (addr),
    .bs_out_buf_wb_rdata  (rdata),
    .m_data               (m_data),
    .m_valid              (m_valid),
    .m_ready              (m_ready),
    .m_last               (m_last),
    .bs_wb_busy           (busy),
    .bs_wb_tile_end       (tile_end)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {22'h2A5A5A, a, 22'h15A5A5, ~a};
  endfunction

  // Output-buffer model and scoreboard push: a read seen in cycle c supplies
  // data during cycle c+1; its expected beat is queued immediately.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_rd = 1'b0;
      s_rd    = 1'b0;
      s_pop   = 1'b0;
      rdata   = '0;
    end else begin
      rdata     = pend_rd ? data_of(pend_addr) : 64'hDEAD_BEEF_0BAD_F00D;
      pend_rd   = rd_en;
      pend_addr = addr;
      s_rd      = rd_en;
      s_pop     = m_valid & m_ready;
      if (rd_en) exp_q.push_back(data_of(addr));
    end
  end

  // Occupancy model built from observed reads and pops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_m  = 0;
      infl_m = 0;
    end else begin
      occ_m  = occ_m + infl_m - (s_pop ? 1 : 0);
      infl_m = s_rd ? 1 : 0;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bs_wb_tile_start = 1'b0;
    m_ready = 1'b0;
    bs_subtile_K = '0;
    bs_opt_subtile_HWCIJ = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({rd_en, m_valid, m_last, busy, tile_end} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 00000", {rd_en, m_valid, m_last, busy, tile_end});
    end
    tests_run++;
    if ({addr, m_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: addr %0h data %0h required 0", addr, m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: ready high; 1: ready toggling; 2: ready low until cycle 10;
  // 3: ready high with a start mid-tile and one on the tile_end cycle.
  task automatic test_stream(input int k, input int h, input int mode);
    int n = k * h;
    int beats = 0;
    int reads = 0;
    int cyc = 0;
    int first_valid = -1;
    bit done = 1'b0;
    bit stalled = 1'b0;
    bit pop;
    logic [DW-1:0] hold_d = '0;
    logic hold_l = 1'b0;
    logic [DW-1:0] exp_d;

    @(posedge clk); #1;
    bs_subtile_K = 8'(k);
    bs_opt_subtile_HWCIJ = 24'(h);
    bs_wb_tile_start = 1'b1;
    m_ready = (mode != 2);
    @(posedge clk); #1;
    cyc = 1;
    while (!done && cyc < 200) begin
      bs_wb_tile_start = (mode == 3) && (cyc == 2 || cyc == 6);
      if (bs_wb_tile_start) begin
        bs_subtile_K = 8'd3;
        bs_opt_subtile_HWCIJ = 24'd3;
      end
      case (mode)
        1:       m_ready = (cyc % 2) == 1;
        2:       m_ready = (cyc >= 10);
        default: m_ready = 1'b1;
      endcase
      @(negedge clk);
      pop = m_valid && m_ready;
      if (rd_en) begin
        tests_run++;
        if (addr !== AW'(reads)) begin
          tests_failed++;
          $display("FAIL rd_addr: got %0d required %0d", addr, reads);
        end
        tests_run++;
        if (occ_m + infl_m - (pop ? 1 : 0) >= 2) begin
          tests_failed++;
          $display("FAIL rd_credit: read with occ %0d inflight %0d pop %0d, required credit < 2", occ_m, infl_m, pop);
        end
        reads++;
      end
      if (stalled) begin
        tests_run++;
        if ({m_valid, m_last, m_data} !== {1'b1, hold_l, hold_d}) begin
          tests_failed++;
          $display("FAIL stall_hold: got v%b l%b %0h required v1 l%b %0h", m_valid, m_last, m_data, hold_l, hold_d);
        end
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (pop) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        tests_run++;
        if (m_data !== exp_d) begin
          tests_failed++;
          $display("FAIL beat_data[%0d]: got %0h required %0h", beats, m_data, exp_d);
        end
        tests_run++;
        if (m_last !== (beats == n - 1)) begin
          tests_failed++;
          $display("FAIL beat_last[%0d]: got %b required %b", beats, m_last, (beats == n - 1));
        end
        tests_run++;
        if (tile_end !== m_last) begin
          tests_failed++;
          $display("FAIL tile_end_on_last[%0d]: got %b required %b", beats, tile_end, m_last);
        end
        if (mode == 0 || mode == 3) begin
          tests_run++;
          if (cyc != first_valid + beats) begin
            tests_failed++;
            $display("FAIL throughput: beat %0d at cycle %0d required %0d", beats, cyc, first_valid + beats);
          end
        end
        beats++;
        if (m_last) done = 1'b1;
      end else begin
        tests_run++;
        if (tile_end !== 1'b0) begin
          tests_failed++;
          $display("FAIL tile_end_spurious: got 1 at cycle %0d required 0", cyc);
        end
      end
      if (mode == 2 && cyc == 9) begin
        tests_run++;
        if (reads != 2 || occ_m + infl_m != 2) begin
          tests_failed++;
          $display("FAIL stall_outstanding: reads %0d occ+inflight %0d required 2 and 2", reads, occ_m + infl_m);
        end
      end
      stalled = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
      @(posedge clk); #1;
      cyc++;
    end
    bs_wb_tile_start = 1'b0;
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL tile_timeout: beats %0d reads %0d, required completion of %0d", beats, reads, n);
    end
    tests_run++;
    if (beats != n || reads != n) begin
      tests_failed++;
      $display("FAIL tile_count: beats %0d reads %0d required %0d", beats, reads, n);
    end
    tests_run++;
    if (first_valid != 3) begin
      tests_failed++;
      $display("FAIL first_valid_latency: got %0d required 3", first_valid);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_left: got %0d entries required 0", exp_q.size());
    end
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if ({rd_en, busy, m_valid, tile_end} !== 4'b0) begin
        tests_failed++;
        $display("FAIL post_tile_idle: got %b required 0000", {rd_en, busy, m_valid, tile_end});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero();
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      bs_subtile_K = (v == 0) ? 8'd0 : 8'd9;
      bs_opt_subtile_HWCIJ = (v == 0) ? 24'd5 : 24'd0;
      bs_wb_tile_start = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({tile_end, busy, rd_en, m_valid} !== 4'b0) begin
        tests_failed++;
        $display("FAIL zero_start_cycle[%0d]: got %b required 0000", v, {tile_end, busy, rd_en, m_valid});
      end
      @(posedge clk); #1;
      // start coincident with tile_end, with a non-zero tile, must be dropped
      bs_subtile_K = 8'd1;
      bs_opt_subtile_HWCIJ = 24'd1;
      @(negedge clk);
      tests_run++;
      if ({tile_end, busy, rd_en, m_valid} !== 4'b1000) begin
        tests_failed++;
        $display("FAIL zero_tile_end[%0d]: got %b required 1000", v, {tile_end, busy, rd_en, m_valid});
      end
      @(posedge clk); #1;
      bs_wb_tile_start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        tests_run++;
        if ({tile_end, busy, rd_en, m_valid} !== 4'b0) begin
          tests_failed++;
          $display("FAIL zero_after[%0d/%0d]: got %b required 0000", v, c, {tile_end, busy, rd_en, m_valid});
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bs_subtile_K = 8'd2;
    bs_opt_subtile_HWCIJ = 24'd4;
    bs_wb_tile_start = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    bs_wb_tile_start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== data_of(AW'(3))) begin
      tests_failed++;
      $display("FAIL mid_beat3: v%b data %0h required v1 %0h", m_valid, m_data, data_of(AW'(3)));
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({rd_en, m_valid, m_last, busy, tile_end} !== 5'b0 || {addr, m_data} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: ctrl %b addr %0h data %0h required 0", {rd_en, m_valid, m_last, busy, tile_end}, addr, m_data);
    end
    exp_q.delete();
    repeat (2) begin
      @(posedge clk); #1;
      tests_run++;
      if (tile_end !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_reset_tile_end: got 1 required 0");
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    test_stream(1, 2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  initial begin
    bs_wb_tile_start = 1'b0;
    m_ready = 1'b0;
    bs_subtile_K = '0;
    bs_opt_subtile_HWCIJ = '0;
    test_reset();
    test_stream(2, 4, 0);
    test_stream(1, 5, 1);
    test_stream(1, 3, 2);
    test_stream(2, 2, 3);
    test_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
